// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Reads one- or two-byte instructions
//               from a registered ROM, presents them to the decoder, and
//               redirects the PC for branch, call/return and interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter int         STACK_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [7:0] ROM_ADDRESS,
  input  logic [7:0] ROM_DATA,
  output logic       INSTR_VALID,
  input  logic       INSTR_READY,
  output logic [7:0] OPCODE,
  output logic [7:0] OPERAND,
  input  logic       BRANCH_EN,
  input  logic [7:0] BRANCH_ADDR,
  input  logic       CALL_EN,
  input  logic       RET_EN,
  input  logic       IRET_EN,
  input  logic [1:0] IRQ,
  output logic [1:0] IRQ_ACK,
  output logic       STACK_ERR
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);
  localparam logic [SPW-1:0] c_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_ADDR  = 3'd0,
    OP_WAIT  = 3'd1,
    ARG_ADDR = 3'd2,
    ARG_WAIT = 3'd3,
    PRESENT  = 3'd4,
    VEC_ADDR = 3'd5,
    VEC_WAIT = 3'd6
  } state_t;

  state_t           r_state;
  logic [7:0]       r_pc;
  logic [7:0]       r_rom_addr;
  logic             r_valid;
  logic [7:0]       r_opcode;
  logic [7:0]       r_operand;
  logic [1:0]       r_irq_ack;
  logic             r_err;
  logic             r_ien;
  logic [SPW-1:0]   r_sp;
  logic [7:0]       r_stack [STACK_DEPTH];

  logic             w_hs;
  logic [7:0]       w_seq_pc;
  logic [7:0]       w_next_pc;
  logic [7:0]       w_stack [STACK_DEPTH];
  logic [SPW-1:0]   w_sp;
  logic             w_err;
  logic             w_ien;
  logic             w_take;
  logic [1:0]       w_ack;
  logic [7:0]       w_vec;

  assign w_hs     = r_valid & INSTR_READY;
  assign w_seq_pc = r_pc + (r_opcode[7] ? 8'd2 : 8'd1);

  // Handshake resolution: the instruction's own stack op first, then an
  // interrupt may push the resulting next PC on top of it in the same cycle.
  always_comb begin
    w_stack   = r_stack;
    w_sp      = r_sp;
    w_err     = 1'b0;
    w_ien     = r_ien;
    w_next_pc = w_seq_pc;
    w_take    = 1'b0;
    w_ack     = 2'b00;
    w_vec     = 8'hFF;
    if (RET_EN || IRET_EN) begin
      if (w_sp == '0) begin
        w_next_pc = RESET_VECTOR;
        w_err     = 1'b1;
      end else begin
        w_sp      = w_sp - SPW'(1);
        w_next_pc = r_stack[w_sp[IW-1:0]];
      end
      if (IRET_EN) w_ien = 1'b1;
    end else if (CALL_EN) begin
      w_next_pc = BRANCH_ADDR;
      if (w_sp == c_FULL) begin
        w_err = 1'b1;
      end else begin
        w_stack[w_sp[IW-1:0]] = w_seq_pc;
        w_sp                  = w_sp + SPW'(1);
      end
    end else if (BRANCH_EN) begin
      w_next_pc = BRANCH_ADDR;
    end
    // Enable is judged before this instruction, so an IRET returns first.
    if (r_ien && (IRQ != 2'b00)) begin
      w_take = 1'b1;
      w_ien  = 1'b0;
      if (w_sp == c_FULL) begin
        w_err = 1'b1;
      end else begin
        w_stack[w_sp[IW-1:0]] = w_next_pc;
        w_sp                  = w_sp + SPW'(1);
      end
      if (IRQ[0]) begin
        w_ack = 2'b01;
        w_vec = 8'hFF;
      end else begin
        w_ack = 2'b10;
        w_vec = 8'hFE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= OP_ADDR;
      r_pc       <= RESET_VECTOR;
      r_rom_addr <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_opcode   <= 8'h00;
      r_operand  <= 8'h00;
      r_irq_ack  <= 2'b00;
      r_err      <= 1'b0;
      r_ien      <= 1'b1;
      r_sp       <= '0;
    end else begin
      r_irq_ack <= 2'b00;
      case (r_state)
        OP_ADDR: r_state <= OP_WAIT;
        OP_WAIT: begin
          r_opcode <= ROM_DATA;
          if (ROM_DATA[7]) begin
            r_rom_addr <= r_pc + 8'd1;
            r_state    <= ARG_ADDR;
          end else begin
            r_operand <= 8'h00;
            r_valid   <= 1'b1;
            r_state   <= PRESENT;
          end
        end
        ARG_ADDR: r_state <= ARG_WAIT;
        ARG_WAIT: begin
          r_operand <= ROM_DATA;
          r_valid   <= 1'b1;
          r_state   <= PRESENT;
        end
        PRESENT: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_stack <= w_stack;
            r_sp    <= w_sp;
            r_err   <= r_err | w_err;
            r_ien   <= w_ien;
            if (w_take) begin
              r_irq_ack  <= w_ack;
              r_rom_addr <= w_vec;
              r_state    <= VEC_ADDR;
            end else begin
              r_pc       <= w_next_pc;
              r_rom_addr <= w_next_pc;
              r_state    <= OP_ADDR;
            end
          end
        end
        VEC_ADDR: r_state <= VEC_WAIT;
        VEC_WAIT: begin
          r_pc       <= ROM_DATA;
          r_rom_addr <= ROM_DATA;
          r_state    <= OP_ADDR;
        end
        default: r_state <= OP_ADDR;
      endcase
    end
  end

  assign ROM_ADDRESS = r_rom_addr;
  assign INSTR_VALID = r_valid;
  assign OPCODE      = r_opcode;
  assign OPERAND     = r_operand;
  assign IRQ_ACK     = r_irq_ack;
  assign STACK_ERR   = r_err;

endmodule

`default_nettype wire
